regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised multi-width register file for the 32-bit RISC datapath.
- Successor to the fixed 32x32 two-read-port file.
- Adds:
  - configurable width and depth
  - byte-enable writes
  - optional hardwired-zero register 0
  - write-to-read bypass
  - per-register busy scoreboard, used by issue logic to detect RAW hazards on in-flight results
- Sits between decode/issue (read selects, lock requests) and writeback (write port).

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 5, select width; NUM_REGS = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and locks
BYPASS, 1, 1 = same-cycle write data forwarded to matching read port

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset; clears all registers and busy bits
wen  in  1  write enable
wsel  in  ADDR_W  write register select
wdata  in  DATA_W  write data
wbe  in  DATA_W/8  byte enables for write; bit i covers wdata[8i+7:8i]
asel  in  ADDR_W  read port A select
bsel  in  ADDR_W  read port B select
aout  out  DATA_W  read port A data
bout  out  DATA_W  read port B data
a_busy  out  1  register selected by asel has a pending result
b_busy  out  1  register selected by bsel has a pending result
lock_en  in  1  mark lock_sel busy (instruction issued targeting it)
lock_sel  in  ADDR_W  register to mark busy
busy_vec  out  NUM_REGS  raw scoreboard state

Behaviour:
- Reset (reset low, asynchronous):
  - all NUM_REGS registers = 0; all busy bits = 0
  - aout/bout = 0, a_busy/b_busy = 0, busy_vec = 0 while reset is held
  - release takes effect at the next rising clk edge; no extra sync stage
- Write: on rising clk with wen=1, bytes of reg[wsel] whose wbe bit = 1 take wdata; other bytes hold.
  - wen=1 with wbe=0 writes nothing, but still clears busy (see below).
- Read: combinational, zero latency.
  - aout = reg[asel], bout = reg[bsel].
- Bypass (BYPASS=1):
  - if wen=1 and wsel==asel, aout = per-byte merge (wbe ? wdata : reg[asel]); same rule for port B.
  - BYPASS=0: reads return the pre-edge value; the new value is visible the cycle after the write.
- Scoreboard, on rising clk:
  - wen=1 clears busy[wsel]
  - lock_en=1 sets busy[lock_sel]
  - same register in the same cycle: lock wins, busy = 1 (new producer issued as old one retires)
  - lock on an already-busy register: stays 1, no error
  - write to a non-busy register: allowed, busy stays 0
- Busy outputs:
  - a_busy = busy[asel]; b_busy = busy[bsel]
  - with BYPASS=1, a_busy is forced 0 when wen=1, wsel==asel and no same-cycle lock to asel (result is being forwarded); same for port B.
- ZERO_REG=1:
  - reg[0] and busy[0] are constant 0; writes and locks to 0 are discarded
  - reads of 0 return 0 including under bypass; a_busy/b_busy for select 0 = 0
- Both read ports may select the same register; both return identical data/busy.
- wsel/asel/bsel/lock_sel are always in range (full decode, no X on any select value).

Decomposition:
- Shared package regfile_pkg:
  - defaults DATA_W_DEF=32, ADDR_W_DEF=5
  - derived localparams NUM_REGS, BE_W=DATA_W/8
  - function byte_merge(old, new, be)
- One sub-module, regfile_read_port, instantiated twice (A, B). It contains:
  - select mux
  - bypass compare and merge
  - busy lookup and override
  - ZERO_REG masking
- Top holds the storage array, write decode and scoreboard.

Test Plan:
- Reset value:
  - assert reset=0 mid-run after writing reg5=0xDEADBEEF → aout for asel=5 is 0x0 immediately (before next clk)
  - busy_vec=0
- Byte-enable write:
  - write reg3=0x11223344 wbe=4'hF, then wdata=0xAABBCCDD wbe=4'b0101 → reg3 reads 0x11BB33DD
- Bypass:
  - BYPASS=1: same cycle wen=1, wsel=7, wdata=0x55, asel=7 → aout=0x55 and a_busy=0 in that cycle
  - BYPASS=0: old value in that cycle, 0x55 on the next cycle
- Scoreboard:
  - lock_sel=9 → b_busy=1 next cycle for bsel=9
  - write reg9 → busy clears after the edge
  - simultaneous lock_sel=9 and wsel=9 → busy_vec[9]=1, data updated
- Zero register:
  - ZERO_REG=1: write reg0=0xFFFFFFFF with lock_sel=0 → aout=0, a_busy=0, busy_vec[0]=0
  - ZERO_REG=0: same stimulus → aout=0xFFFFFFFF
- Parametrisation:
  - DATA_W=64, ADDR_W=3 build: write all 8 registers with distinct 64-bit patterns using wbe=8'hFF
  - read all 8 back on both ports simultaneously, values match

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and byte-merge helper for the register file
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;
  localparam int BE_W       = DATA_W_DEF / 8;

  // Widest datapath the merge helper handles; callers zero-extend into it and truncate back.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  // Per-byte select: bytes with their enable set come from new_data, the rest keep old_data.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_data,
    input logic [MAX_DATA_W-1:0] new_data,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    for (int i = 0; i < MAX_BE_W; i++) begin
      res[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port with bypass, busy lookup and zero masking
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                reset,
  input  logic [DATA_W-1:0]   regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy_vec,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   wsel,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                lock_en,
  input  logic [ADDR_W-1:0]   lock_sel,
  input  logic [ADDR_W-1:0]   sel,
  output logic [DATA_W-1:0]   data,
  output logic                busy
);

  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] merged;
  logic              hit;
  logic              lock_hit;
  logic              is_zero;

  assign stored   = regs[sel];
  assign hit      = BYPASS && wen && (wsel == sel);
  assign lock_hit = lock_en && (lock_sel == sel);
  assign is_zero  = ZERO_REG && (sel == '0);
  assign merged   = DATA_W'(byte_merge(MAX_DATA_W'(stored), MAX_DATA_W'(wdata), MAX_BE_W'(wbe)));

  // Pick stored or forwarded data; a forwarded result is no longer pending unless re-locked now.
  always_comb begin
    data = stored;
    busy = busy_vec[sel];
    if (hit) begin
      data = merged;
      if (!lock_hit) begin
        busy = 1'b0;
      end
    end
    if (is_zero) begin
      data = '0;
      busy = 1'b0;
    end
    if (!reset) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file storage, byte-enable write port and busy scoreboard
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wen,
  input  logic [ADDR_W-1:0]    wsel,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [DATA_W/8-1:0]  wbe,
  input  logic [ADDR_W-1:0]    asel,
  input  logic [ADDR_W-1:0]    bsel,
  output logic [DATA_W-1:0]    aout,
  output logic [DATA_W-1:0]    bout,
  output logic                 a_busy,
  output logic                 b_busy,
  input  logic                 lock_en,
  input  logic [ADDR_W-1:0]    lock_sel,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int N_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [N_REGS];
  logic [N_REGS-1:0] busy_q;
  logic [N_REGS-1:0] busy_nxt;
  logic              wr_ok;
  logic [DATA_W-1:0] wr_merged;

  // Register 0 is never stored when it is hardwired, so it stays at its reset value of 0.
  assign wr_ok     = wen && !(ZERO_REG && (wsel == '0));
  assign wr_merged = DATA_W'(byte_merge(MAX_DATA_W'(regs[wsel]), MAX_DATA_W'(wdata), MAX_BE_W'(wbe)));

  // Storage array: async clear, byte-enable write on the rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wsel] <= wr_merged;
    end
  end

  // Scoreboard next state: retire clears, issue sets, so a same-cycle lock overrides the retire.
  always_comb begin
    busy_nxt = busy_q;
    if (wen) begin
      busy_nxt[wsel] = 1'b0;
    end
    if (lock_en) begin
      busy_nxt[lock_sel] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_nxt[0] = 1'b0;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port_a (
    .reset    (reset),
    .regs     (regs),
    .busy_vec (busy_q),
    .wen      (wen),
    .wsel     (wsel),
    .wdata    (wdata),
    .wbe      (wbe),
    .lock_en  (lock_en),
    .lock_sel (lock_sel),
    .sel      (asel),
    .data     (aout),
    .busy     (a_busy)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port_b (
    .reset    (reset),
    .regs     (regs),
    .busy_vec (busy_q),
    .wen      (wen),
    .wsel     (wsel),
    .wdata    (wdata),
    .wbe      (wbe),
    .lock_en  (lock_en),
    .lock_sel (lock_sel),
    .sel      (bsel),
    .data     (bout),
    .busy     (b_busy)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized model-checked bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic [4:0]  wsel;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [4:0]  asel;
  logic [4:0]  bsel;
  logic        lock_en;
  logic [4:0]  lock_sel;

  logic [31:0] aout0, bout0, aout1, bout1;
  logic        abusy0, bbusy0, abusy1, bbusy1;
  logic [31:0] bv0, bv1;

  logic        w_wen;
  logic [2:0]  w_wsel, w_asel, w_bsel, w_lock_sel;
  logic [63:0] w_wdata;
  logic [7:0]  w_wbe;
  logic        w_lock_en;
  logic [63:0] w_aout, w_bout;
  logic        w_abusy, w_bbusy;
  logic [7:0]  w_bv;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: index 0 = hardwired zero + bypass, index 1 = plain register, no bypass.
  logic [31:0] m_reg  [2][32];
  bit          m_busy [2][32];
  logic [63:0] pat    [8];

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .wen(wen), .wsel(wsel), .wdata(wdata), .wbe(wbe),
    .asel(asel), .bsel(bsel), .aout(aout0), .bout(bout0), .a_busy(abusy0), .b_busy(bbusy0),
    .lock_en(lock_en), .lock_sel(lock_sel), .busy_vec(bv0));

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .wen(wen), .wsel(wsel), .wdata(wdata), .wbe(wbe),
    .asel(asel), .bsel(bsel), .aout(aout1), .bout(bout1), .a_busy(abusy1), .b_busy(bbusy1),
    .lock_en(lock_en), .lock_sel(lock_sel), .busy_vec(bv1));

  regfile_scoreboard #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_wide (
    .clk(clk), .reset(reset), .wen(w_wen), .wsel(w_wsel), .wdata(w_wdata), .wbe(w_wbe),
    .asel(w_asel), .bsel(w_bsel), .aout(w_aout), .bout(w_bout), .a_busy(w_abusy), .b_busy(w_bbusy),
    .lock_en(w_lock_en), .lock_sel(w_lock_sel), .busy_vec(w_bv));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input int v, input logic [4:0] sel);
    logic [31:0] val;
    if (v == 0 && sel == 5'd0) return 32'h0;
    val = m_reg[v][sel];
    if (v == 0 && wen && wsel == sel) begin
      for (int i = 0; i < 4; i++) if (wbe[i]) val[8*i +: 8] = wdata[8*i +: 8];
    end
    return val;
  endfunction

  function automatic logic exp_busy(input int v, input logic [4:0] sel);
    if (v == 0 && sel == 5'd0) return 1'b0;
    if (v == 0 && wen && wsel == sel && !(lock_en && lock_sel == sel)) return 1'b0;
    return m_busy[v][sel];
  endfunction

  function automatic logic [31:0] exp_bv(input int v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = m_busy[v][i];
    return r;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 2; v++)
      for (int i = 0; i < 32; i++) begin
        m_reg[v][i]  = 32'h0;
        m_busy[v][i] = 1'b0;
      end
  endtask

  task automatic model_update();
    for (int v = 0; v < 2; v++) begin
      if (wen && !(v == 0 && wsel == 5'd0))
        for (int i = 0; i < 4; i++) if (wbe[i]) m_reg[v][wsel][8*i +: 8] = wdata[8*i +: 8];
      if (wen) m_busy[v][wsel] = 1'b0;
      if (lock_en && !(v == 0 && lock_sel == 5'd0)) m_busy[v][lock_sel] = 1'b1;
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1;
    check("a0_data", aout0, exp_read(0, asel));
    check("b0_data", bout0, exp_read(0, bsel));
    check("a0_busy", abusy0, exp_busy(0, asel));
    check("b0_busy", bbusy0, exp_busy(0, bsel));
    check("busy_vec0", bv0, exp_bv(0));
    check("a1_data", aout1, exp_read(1, asel));
    check("b1_data", bout1, exp_read(1, bsel));
    check("a1_busy", abusy1, exp_busy(1, asel));
    check("b1_busy", bbusy1, exp_busy(1, bsel));
    check("busy_vec1", bv1, exp_bv(1));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic logic [4:0] rand_sel();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
  endfunction

  task automatic random_steps(input int n);
    for (int k = 0; k < n; k++) begin
      wen      = 1'($urandom);
      wsel     = rand_sel();
      wdata    = $urandom;
      wbe      = 4'($urandom);
      asel     = rand_sel();
      bsel     = ($urandom_range(0, 3) == 0) ? asel : rand_sel();
      lock_en  = 1'($urandom);
      lock_sel = rand_sel();
      step();
    end
  endtask

  initial begin
    reset = 1'b0;
    wen = 0; wsel = 0; wdata = 0; wbe = 0; asel = 0; bsel = 0; lock_en = 0; lock_sel = 0;
    w_wen = 0; w_wsel = 0; w_wdata = 0; w_wbe = 0; w_asel = 0; w_bsel = 0;
    w_lock_en = 0; w_lock_sel = 0;
    model_reset();

    @(negedge clk);
    #1;
    check("init_a0", aout0, 0);
    check("init_bv0", bv0, 0);
    check("init_bv1", bv1, 0);
    @(negedge clk);
    reset = 1'b1;

    // Same-cycle forwarding versus registered read.
    wen = 1; wsel = 7; wdata = 32'h55; wbe = 4'hF; asel = 7; bsel = 0;
    #1;
    check("byp_a0", aout0, 32'h55);
    check("byp_abusy0", abusy0, 0);
    check("nobyp_a1", aout1, 32'h0);
    step();
    wen = 0;
    #1;
    check("nobyp_next_a1", aout1, 32'h55);
    step();

    // Byte-enable write.
    wen = 1; wsel = 3; wdata = 32'h11223344; wbe = 4'hF; asel = 0;
    step();
    wdata = 32'hAABBCCDD; wbe = 4'b0101;
    step();
    wen = 0; asel = 3;
    #1;
    check("be_a0", aout0, 32'h11BB33DD);
    check("be_a1", aout1, 32'h11BB33DD);
    step();

    // Scoreboard lock, retire, and lock-during-retire.
    lock_en = 1; lock_sel = 9; bsel = 9;
    step();
    lock_en = 0;
    #1;
    check("lock_b0", bbusy0, 1);
    check("lock_b1", bbusy1, 1);
    wen = 1; wsel = 9; wdata = 32'hCAFE; wbe = 4'hF;
    #1;
    check("fwd_b0_busy", bbusy0, 0);
    check("nofwd_b1_busy", bbusy1, 1);
    step();
    wen = 0;
    #1;
    check("clr_bv0", bv0[9], 0);
    step();
    wen = 1; wsel = 9; wdata = 32'h1234; lock_en = 1; lock_sel = 9;
    step();
    wen = 0; lock_en = 0;
    #1;
    check("relock_bv0", bv0[9], 1);
    check("relock_b0", bout0, 32'h1234);
    step();

    // Hardwired zero register.
    wen = 1; wsel = 0; wdata = 32'hFFFFFFFF; wbe = 4'hF; lock_en = 1; lock_sel = 0; asel = 0; bsel = 0;
    #1;
    check("zero_a0", aout0, 0);
    check("zero_abusy0", abusy0, 0);
    step();
    wen = 0; lock_en = 0;
    #1;
    check("zero_a0_next", aout0, 0);
    check("zero_bv0", bv0[0], 0);
    check("zero_a1", aout1, 32'hFFFFFFFF);
    check("zero_bv1", bv1[0], 1);
    step();

    random_steps(400);

    // Asynchronous reset mid-run.
    wen = 1; wsel = 5; wdata = 32'hDEADBEEF; wbe = 4'hF; lock_en = 1; lock_sel = 6;
    step();
    wen = 0; lock_en = 0; asel = 5; bsel = 6;
    #1;
    check("pre_rst_a0", aout0, 32'hDEADBEEF);
    reset = 1'b0;
    #1;
    check("rst_a0", aout0, 0);
    check("rst_a1", aout1, 0);
    check("rst_b0_busy", bbusy0, 0);
    check("rst_bv0", bv0, 0);
    check("rst_bv1", bv1, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    random_steps(150);
    wen = 0; lock_en = 0;

    // 64-bit, 8-register build: fill and read back on both ports.
    for (int i = 0; i < 8; i++) begin
      pat[i] = {$urandom, $urandom};
      pat[i][63:60] = 4'(i);
    end
    for (int i = 0; i < 8; i++) begin
      w_wen = 1; w_wsel = 3'(i); w_wdata = pat[i]; w_wbe = 8'hFF;
      @(posedge clk);
      @(negedge clk);
    end
    w_wen = 0;
    for (int i = 0; i < 8; i++) begin
      w_asel = 3'(i); w_bsel = 3'(i);
      #1;
      check("wide_a", w_aout, pat[i]);
      check("wide_b", w_bout, pat[i]);
      w_bsel = 3'(7 - i);
      #1;
      check("wide_b_other", w_bout, pat[7 - i]);
      @(negedge clk);
    end
    check("wide_bv", w_bv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
